// File: rtl/regs_wb_arbiter_pkg.sv
// Shared register-heap definitions used by the writeback arbiter and its FIFO.
package regs_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'h0;

endpackage

// File: rtl/regs_wb_arbiter_wb_fifo.sv
// Generic synchronous FIFO with a combinational head view, so the consumer
// can act on the head entry in the same cycle it decides to pop it.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a pop frees a slot for a same-cycle push.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-heap write port arbiter: pipeline writeback has priority, MDU
// results queue in a FIFO, a pending scoreboard drives decode stalls, and a
// starvation counter requests a one-cycle writeback bubble.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_waddr,
    input  logic [REG_DATA_W-1:0] pipe_wval,
    input  logic                  mdu_issue,
    input  logic [REG_ADDR_W-1:0] mdu_issue_addr,
    output logic                  issue_ready,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_waddr,
    input  logic [REG_DATA_W-1:0] mdu_wval,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    output logic                  id_stall,
    output logic                  wb_hold,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_addr,
    output logic [REG_DATA_W-1:0] write_val,
    output logic [31:0]           pending
);

    localparam int ENTRY_W  = REG_ADDR_W + REG_DATA_W;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

    logic [ENTRY_W-1:0]    fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [REG_DATA_W-1:0] head_val;
    logic                  pipe_wins;
    logic                  losing;
    logic                  issue_accept;
    logic                  unused_fifo_status;

    logic [31:0]           pending_q, pending_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d, starve_inc;
    logic                  wb_hold_q, wb_hold_d;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mdu_valid),
        .push_data ({mdu_waddr, mdu_wval}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Occupancy is tracked by the outstanding counter, which bounds the FIFO.
    assign unused_fifo_status = ^{fifo_count, fifo_full};

    assign head_addr    = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
    assign head_val     = fifo_head[REG_DATA_W-1:0];
    assign pipe_wins    = pipe_we && (pipe_waddr != REG_ZERO);
    assign losing       = pipe_wins && !fifo_empty;
    assign issue_ready  = !pending_q[mdu_issue_addr] && (outstanding_q < CNT_W'(DEPTH));
    assign issue_accept = mdu_issue && issue_ready;
    assign id_stall     = pending_q[id_rs_addr] | pending_q[id_rt_addr] | pending_q[id_waddr];
    assign pending      = pending_q;
    assign wb_hold      = wb_hold_q;

    // Write-port arbitration: pipeline first, then the FIFO head; a head
    // destined for r0 still pops but never writes.
    always_comb begin
        write_enable = 1'b0;
        write_addr   = REG_ZERO;
        write_val    = '0;
        fifo_pop     = 1'b0;
        if (pipe_wins) begin
            write_enable = 1'b1;
            write_addr   = pipe_waddr;
            write_val    = pipe_wval;
        end else if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            write_enable = (head_addr != REG_ZERO);
            write_addr   = head_addr;
            write_val    = head_val;
        end
        if (!rst_n) begin
            write_enable = 1'b0;
        end
    end

    // Scoreboard, outstanding-op count and starvation tracking.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[head_addr] = 1'b0;
        end
        if (issue_accept && (mdu_issue_addr != REG_ZERO)) begin
            pending_d[mdu_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q + CNT_W'(issue_accept) - CNT_W'(fifo_pop);

        starve_inc   = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        starve_cnt_d = losing ? starve_inc : '0;
        wb_hold_d    = losing && (starve_inc == STARVE_MAX);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            starve_cnt_q  <= '0;
            wb_hold_q     <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            starve_cnt_q  <= starve_cnt_d;
            wb_hold_q     <= wb_hold_d;
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed self-checking bench for regs_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wval;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        issue_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wval;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_waddr;
    logic        id_stall;
    logic        wb_hold;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_val;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;

    regs_wb_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_we        (pipe_we),
        .pipe_waddr     (pipe_waddr),
        .pipe_wval      (pipe_wval),
        .mdu_issue      (mdu_issue),
        .mdu_issue_addr (mdu_issue_addr),
        .issue_ready    (issue_ready),
        .mdu_valid      (mdu_valid),
        .mdu_waddr      (mdu_waddr),
        .mdu_wval       (mdu_wval),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_waddr       (id_waddr),
        .id_stall       (id_stall),
        .wb_hold        (wb_hold),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_val      (write_val),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // Protocol watch: an MDU result must never arrive while the FIFO is full.
    always @(posedge clk) begin
        if (rst_n && mdu_valid && u_dut.u_fifo.full) begin
            checks++;
            failures++;
            $display("FAIL mdu_valid_while_full: got push with full=1 required full=0");
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        pipe_we        = 1'b0;
        pipe_waddr     = 5'd0;
        pipe_wval      = 32'd0;
        mdu_issue      = 1'b0;
        mdu_issue_addr = 5'd0;
        mdu_valid      = 1'b0;
        mdu_waddr      = 5'd0;
        mdu_wval       = 32'd0;
        id_rs_addr     = 5'd0;
        id_rt_addr     = 5'd0;
        id_waddr       = 5'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wval = 32'h33;
        step(); #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL rst_we_forced: got %b required 0", write_enable); end
        step();
        pipe_we = 1'b0; rst_n = 1'b1; #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL rst_we_idle: got %b required 0", write_enable); end
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL rst_pending: got %h required 0", pending); end
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL rst_issue_ready: got %b required 1", issue_ready); end
        checks++; if (wb_hold !== 1'b0) begin failures++; $display("FAIL rst_wb_hold: got %b required 0", wb_hold); end
        checks++; if (id_stall !== 1'b0) begin failures++; $display("FAIL rst_id_stall: got %b required 0", id_stall); end
        step(); #1;
        checks++; if (pending !== 32'h0 || write_enable !== 1'b0) begin failures++; $display("FAIL idle_after_rst: got pending=%h we=%b required 0/0", pending, write_enable); end
        $display("test_reset done");
    endtask

    task automatic test_mdu_basic;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd8; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b required 1", issue_ready); end
        step(); mdu_issue = 1'b0; id_rs_addr = 5'd8; #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL basic_stall: got %b required 1", id_stall); end
        checks++; if (pending !== 32'h100) begin failures++; $display("FAIL basic_pending: got %h required 00000100", pending); end
        step(); #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL basic_no_we: got %b required 0", write_enable); end
        step(); mdu_valid = 1'b1; mdu_waddr = 5'd8; mdu_wval = 32'hDEADBEEF; #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL basic_push_no_we: got %b required 0", write_enable); end
        step(); mdu_valid = 1'b0; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd8 || write_val !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_write: got we=%b addr=%0d val=%h required 1/8/deadbeef", write_enable, write_addr, write_val); end
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL basic_stall_hold: got %b required 1", id_stall); end
        step(); #1;
        checks++; if (pending !== 32'h0 || id_stall !== 1'b0 || write_enable !== 1'b0) begin failures++; $display("FAIL basic_clear: got pending=%h stall=%b we=%b required 0/0/0", pending, id_stall, write_enable); end
        id_rs_addr = 5'd0;
        $display("test_mdu_basic done");
    endtask

    task automatic test_collision;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd5; id_rt_addr = 5'd5; #1;
        checks++; if (issue_ready !== 1'b1 || id_stall !== 1'b0) begin failures++; $display("FAIL coll_ready: got ready=%b stall=%b required 1/0", issue_ready, id_stall); end
        step(); mdu_issue = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wval = 32'h11;
        mdu_valid = 1'b1; mdu_waddr = 5'd5; mdu_wval = 32'h22; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_val !== 32'h11) begin failures++; $display("FAIL coll_pipe: got we=%b addr=%0d val=%h required 1/3/11", write_enable, write_addr, write_val); end
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL coll_rt_stall: got %b required 1", id_stall); end
        step(); pipe_we = 1'b0; mdu_valid = 1'b0; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_val !== 32'h22) begin failures++; $display("FAIL coll_mdu: got we=%b addr=%0d val=%h required 1/5/22", write_enable, write_addr, write_val); end
        step(); #1;
        checks++; if (pending !== 32'h0 || write_enable !== 1'b0) begin failures++; $display("FAIL coll_clear: got pending=%h we=%b required 0/0", pending, write_enable); end
        id_rt_addr = 5'd0;
        $display("test_collision done");
    endtask

    task automatic test_pipe_zero_addr;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd12; id_waddr = 5'd12;
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd12; mdu_wval = 32'hC; #1;
        checks++; if (id_stall !== 1'b1) begin failures++; $display("FAIL zero_waw_stall: got %b required 1", id_stall); end
        step(); mdu_valid = 1'b0; pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wval = 32'hBAD; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd12 || write_val !== 32'hC) begin failures++; $display("FAIL zero_pipe_yields: got we=%b addr=%0d val=%h required 1/12/c", write_enable, write_addr, write_val); end
        step(); pipe_we = 1'b0; #1;
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL zero_clear: got %h required 0", pending); end
        id_waddr = 5'd0;
        $display("test_pipe_zero_addr done");
    endtask

    task automatic test_starvation;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd9;
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd9; mdu_wval = 32'h99;
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wval = 32'h1001; #1;
        checks++; if (wb_hold !== 1'b0 || write_addr !== 5'd1) begin failures++; $display("FAIL starve_push: got hold=%b addr=%0d required 0/1", wb_hold, write_addr); end
        for (int i = 0; i < 3; i++) begin
            step(); mdu_valid = 1'b0; pipe_wval = 32'h1002 + i; #1;
            checks++; if (wb_hold !== 1'b0 || write_addr !== 5'd1 || write_val !== 32'h1002 + i || pending !== 32'h200) begin failures++; $display("FAIL starve_lose%0d: got hold=%b addr=%0d val=%h pending=%h required 0/1/%h/00000200", i, wb_hold, write_addr, write_val, pending, 32'h1002 + i); end
        end
        step(); pipe_we = 1'b0; #1;
        checks++; if (wb_hold !== 1'b1) begin failures++; $display("FAIL starve_hold: got %b required 1", wb_hold); end
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd9 || write_val !== 32'h99) begin failures++; $display("FAIL starve_drain: got we=%b addr=%0d val=%h required 1/9/99", write_enable, write_addr, write_val); end
        step(); pipe_we = 1'b1; pipe_wval = 32'h1010; #1;
        checks++; if (wb_hold !== 1'b0 || pending !== 32'h0 || write_addr !== 5'd1) begin failures++; $display("FAIL starve_after: got hold=%b pending=%h addr=%0d required 0/0/1", wb_hold, pending, write_addr); end
        step(); #1;
        checks++; if (wb_hold !== 1'b0) begin failures++; $display("FAIL starve_once: got %b required 0", wb_hold); end
        pipe_we = 1'b0;
        $display("test_starvation done");
    endtask

    task automatic test_hold_violation;
        step(); pipe_we = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd13;
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd13; mdu_wval = 32'h13;
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wval = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            step(); mdu_valid = 1'b0; #1;
        end
        step(); #1;
        checks++; if (wb_hold !== 1'b1 || write_addr !== 5'd1) begin failures++; $display("FAIL viol_hold1: got hold=%b addr=%0d required 1/1", wb_hold, write_addr); end
        step(); pipe_we = 1'b0; #1;
        checks++; if (wb_hold !== 1'b1) begin failures++; $display("FAIL viol_rehold: got %b required 1", wb_hold); end
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd13 || write_val !== 32'h13) begin failures++; $display("FAIL viol_drain: got we=%b addr=%0d val=%h required 1/13/13", write_enable, write_addr, write_val); end
        step(); #1;
        checks++; if (wb_hold !== 1'b0 || pending !== 32'h0) begin failures++; $display("FAIL viol_after: got hold=%b pending=%h required 0/0", wb_hold, pending); end
        $display("test_hold_violation done");
    endtask

    task automatic test_capacity;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd4; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL cap_ready4: got %b required 1", issue_ready); end
        step(); mdu_issue_addr = 5'd6; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL cap_ready6: got %b required 1", issue_ready); end
        step(); mdu_issue_addr = 5'd7; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_full7: got %b required 0", issue_ready); end
        mdu_issue_addr = 5'd4; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_repeat4: got %b required 0", issue_ready); end
        checks++; if (pending !== 32'h50) begin failures++; $display("FAIL cap_pending: got %h required 00000050", pending); end
        step(); mdu_issue_addr = 5'd7; mdu_valid = 1'b1; mdu_waddr = 5'd4; mdu_wval = 32'h44; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_still_full: got %b required 0", issue_ready); end
        step(); mdu_valid = 1'b0; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd4 || write_val !== 32'h44) begin failures++; $display("FAIL cap_pop4: got we=%b addr=%0d val=%h required 1/4/44", write_enable, write_addr, write_val); end
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL cap_pop_cycle: got %b required 0", issue_ready); end
        step(); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL cap_accept7: got %b required 1", issue_ready); end
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd6; mdu_wval = 32'h66; #1;
        checks++; if (pending !== 32'hC0) begin failures++; $display("FAIL cap_pending67: got %h required 000000c0", pending); end
        step(); mdu_waddr = 5'd7; mdu_wval = 32'h77; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd6 || write_val !== 32'h66) begin failures++; $display("FAIL cap_pop6: got we=%b addr=%0d val=%h required 1/6/66", write_enable, write_addr, write_val); end
        step(); mdu_valid = 1'b0; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_val !== 32'h77) begin failures++; $display("FAIL cap_pop7: got we=%b addr=%0d val=%h required 1/7/77", write_enable, write_addr, write_val); end
        step(); #1;
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL cap_drained: got %h required 0", pending); end
        // Destination r0: counted as outstanding, never pending, never written.
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd0; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %b required 1", issue_ready); end
        step(); #1;
        checks++; if (issue_ready !== 1'b1 || pending !== 32'h0) begin failures++; $display("FAIL r0_second: got ready=%b pending=%h required 1/0", issue_ready, pending); end
        step(); mdu_issue_addr = 5'd3; #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL r0_outstanding: got %b required 0", issue_ready); end
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wval = 32'hAA;
        step(); mdu_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd3; #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL r0_pop_no_we: got %b required 0", write_enable); end
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL r0_pop_cycle: got %b required 0", issue_ready); end
        step(); #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL r0_after_pop: got %b required 1", issue_ready); end
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wval = 32'hAB;
        step(); mdu_waddr = 5'd3; mdu_wval = 32'h33; #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL r0_pop2_no_we: got %b required 0", write_enable); end
        step(); mdu_valid = 1'b0; #1;
        checks++; if (write_enable !== 1'b1 || write_addr !== 5'd3 || write_val !== 32'h33) begin failures++; $display("FAIL cap_pop3: got we=%b addr=%0d val=%h required 1/3/33", write_enable, write_addr, write_val); end
        step(); #1;
        checks++; if (pending !== 32'h0) begin failures++; $display("FAIL cap_final: got %h required 0", pending); end
        $display("test_capacity done");
    endtask

    task automatic test_reset_mid_op;
        step(); mdu_issue = 1'b1; mdu_issue_addr = 5'd10;
        step(); mdu_issue_addr = 5'd11;
        step(); mdu_issue = 1'b0; mdu_valid = 1'b1; mdu_waddr = 5'd10; mdu_wval = 32'hA;
        pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wval = 32'h222;
        step(); mdu_waddr = 5'd11; mdu_wval = 32'hB; #1;
        checks++; if (write_addr !== 5'd2 || pending !== 32'hC00) begin failures++; $display("FAIL mid_before: got addr=%0d pending=%h required 2/00000c00", write_addr, pending); end
        step(); mdu_valid = 1'b0; rst_n = 1'b0; #1;
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_we: got %b required 0", write_enable); end
        step(); rst_n = 1'b1; pipe_we = 1'b0; mdu_issue_addr = 5'd10; #1;
        checks++; if (pending !== 32'h0 || write_enable !== 1'b0 || issue_ready !== 1'b1 || wb_hold !== 1'b0) begin failures++; $display("FAIL mid_after: got pending=%h we=%b ready=%b hold=%b required 0/0/1/0", pending, write_enable, issue_ready, wb_hold); end
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL mid_no_write%0d: got %b required 0", i, write_enable); end
        end
        $display("test_reset_mid_op done");
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_mdu_basic();
        test_collision();
        test_pipe_zero_addr();
        test_starvation();
        test_hold_violation();
        test_capacity();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
